inst_mem_responder: RTL

//  Responder end of the CPU instruction-fetch interface (rom_en/rom_addr -> rom_data).

---
 rtl/inst_mem_responder.sv | 102 ++++++++++
 1 files changed

// File: rtl/inst_mem_responder.sv
// Instruction-fetch responder: loadable synchronous instruction RAM behind the
// core's rom_en/rom_addr/rom_data fetch port, with configurable wait states and
// a stall handshake that tells the core when the fetched word is ready.
module inst_mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_en,
  input  logic [31:0]           rom_addr,
  output logic [31:0]           rom_data,
  output logic                  rom_stall,
  output logic                  rom_err,
  input  logic                  ld_we,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
  localparam int unsigned WORDS = 1 << DEPTH_LOG2;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [31:0]           addr_q;
  logic [31:0]           mem [WORDS];

  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  oor_q;
  logic                  mis_q;

  // Decode the captured fetch address: word index, out-of-range and misalignment.
  always_comb begin
    idx_q = addr_q[DEPTH_LOG2+1:2];
    oor_q = |addr_q[31:DEPTH_LOG2+2];
    mis_q = |addr_q[1:0];
  end

  // Stall the core whenever it requests a fetch that is not being delivered this cycle.
  always_comb begin
    rom_stall = rom_en & (state != DONE);
  end

  // Load port: program words may be written at any time; contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // Fetch FSM: capture address, count wait states, then present data for one cycle.
  // A same-edge load write to the word being read yields the old word because the
  // array update and the read both resolve at the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      rom_data <= '0;
      rom_err  <= 1'b0;
    end else begin
      rom_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rom_en) begin
            addr_q <= rom_addr;
            cnt    <= WAIT_INIT;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (!rom_en) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            rom_data <= oor_q ? 32'h0 : mem[idx_q];
            rom_err  <= oor_q | mis_q;
            state    <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (rom_en) begin
            addr_q <= rom_addr;
            cnt    <= WAIT_INIT;
            state  <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
